// File: rtl/ps2_scancode_fifo_ci.sv
// PS/2 scancode assembler feeding a small FIFO, read out through a
// custom-instruction port (POP / PEEK / STATUS / CLEAR, one enabled cycle of latency).
module ps2_scancode_fifo_ci #(
   parameter int DEPTH     = 8,
   parameter int MAX_BYTES = 4,
   parameter int TIMEOUT   = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [1:0]  n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        done,
   output logic [31:0] result,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0]    LAST_IDX  = 2'(MAX_BYTES - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   localparam logic [1:0] OP_POP    = 2'd0;
   localparam logic [1:0] OP_PEEK   = 2'd1;
   localparam logic [1:0] OP_STATUS = 2'd2;
   localparam logic [1:0] OP_CLEAR  = 2'd3;

   typedef enum logic { A_IDLE, A_COLLECT } asm_state_t;
   typedef enum logic { CI_IDLE, CI_RESP } ci_state_t;

   asm_state_t      ast_q;
   logic [23:0]     asm_q;
   logic [1:0]      bcnt_q;
   logic [TW-1:0]   tmr_q;

   ci_state_t       ci_q;
   logic [31:0]     result_q;

   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   rd_q, wr_q;
   logic [CW-1:0]   count_q;
   logic            ovf_q;

   logic            is_prefix, shift_in, push_req, timeout_hit;
   logic [31:0]     push_data;
   logic            ci_accept, pop_en, clr, full, push_en, drop;
   logic [31:0]     head, status_w, op_result_d;

   // Assembler: prefixes accumulate until the final (non-prefix or MAX_BYTES-th) byte.
   assign is_prefix   = (rx_data == 8'hE0) || (rx_data == 8'hF0);
   assign shift_in    = rx_valid && is_prefix && (bcnt_q < LAST_IDX);
   assign push_req    = rx_valid && !shift_in;
   assign push_data   = {asm_q, rx_data};
   assign timeout_hit = (ast_q == A_COLLECT) && !rx_valid && (tmr_q == TMO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ast_q  <= A_IDLE;
         asm_q  <= '0;
         bcnt_q <= '0;
         tmr_q  <= '0;
      end else if (shift_in) begin
         asm_q  <= {asm_q[15:0], rx_data};
         bcnt_q <= bcnt_q + 2'd1;
         ast_q  <= A_COLLECT;
         tmr_q  <= '0;
      end else if (push_req || timeout_hit) begin
         asm_q  <= '0;
         bcnt_q <= '0;
         ast_q  <= A_IDLE;
         tmr_q  <= '0;
      end else if (ast_q == A_COLLECT) begin
         tmr_q  <= tmr_q + TW'(1);
      end
   end

   // FIFO control; CLEAR wins over a same-cycle push, a POP frees room for one.
   assign ci_accept = (ci_q == CI_IDLE) && clk_en && start;
   assign pop_en    = ci_accept && (n == OP_POP) && (count_q != '0);
   assign clr       = ci_accept && (n == OP_CLEAR);
   assign full      = (count_q == FULL_CNT);
   assign push_en   = push_req && !clr && (!full || pop_en);
   assign drop      = push_req && !clr && full && !pop_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (clr) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push_en) wr_q <= wr_q + AW'(1);
         if (pop_en)  rd_q <= rd_q + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (drop) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_q] <= push_data;
   end

   assign head = (count_q != '0) ? mem[rd_q] : 32'h0;

   always_comb begin
      status_w        = '0;
      status_w[31]    = ovf_q;
      status_w[30]    = (ast_q == A_COLLECT);
      status_w[23:16] = 8'(MAX_BYTES);
      status_w[15:8]  = 8'(DEPTH - 1);
      status_w        = status_w | 32'(count_q);
   end

   always_comb begin
      op_result_d = '0;
      case (n)
         OP_POP, OP_PEEK: op_result_d = head;
         OP_STATUS:       op_result_d = status_w;
         default:         op_result_d = '0;
      endcase
   end

   // CI FSM: result is latched when the operation is accepted, done fires on the next enabled cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ci_q     <= CI_IDLE;
         result_q <= '0;
      end else begin
         case (ci_q)
            CI_IDLE: if (ci_accept) begin
               ci_q     <= CI_RESP;
               result_q <= op_result_d;
            end
            CI_RESP: if (clk_en) ci_q <= CI_IDLE;
            default: ci_q <= CI_IDLE;
         endcase
      end
   end

   assign done     = (ci_q == CI_RESP) && clk_en;
   assign result   = result_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_fifo_ci.sv
// Directed bench for ps2_scancode_fifo_ci: hand-computed vectors for assembly,
// FIFO boundaries, coincident push/pop/clear, timeout, clk_en gating and reset.
module tb_ps2_scancode_fifo_ci;

   localparam int DEPTH     = 8;
   localparam int MAX_BYTES = 4;
   localparam int TIMEOUT   = 16;

   localparam logic [1:0] OP_POP    = 2'd0;
   localparam logic [1:0] OP_PEEK   = 2'd1;
   localparam logic [1:0] OP_STATUS = 2'd2;
   localparam logic [1:0] OP_CLEAR  = 2'd3;

   // STATUS with MAX_BYTES=4 at [23:16] and DEPTH-1=7 at [15:8]
   localparam logic [31:0] ST_BASE = 32'h0004_0700;

   logic        clk, reset, clk_en, start, rx_valid;
   logic [1:0]  n;
   logic [7:0]  rx_data;
   logic        done, overflow;
   logic [31:0] result;

   int n_vec = 0;
   int n_err = 0;

   ps2_scancode_fifo_ci #(
      .DEPTH(DEPTH), .MAX_BYTES(MAX_BYTES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .done(done), .result(result), .overflow(overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic ci_op(input logic [1:0] op, input string tag, input logic [31:0] exp);
      @(negedge clk);
      n      = op;
      start  = 1'b1;
      clk_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, " done"}, 32'(done), 32'd1);
      check_eq({tag, " result"}, result, exp);
      @(negedge clk);
      check_eq({tag, " done_low"}, 32'(done), 32'd0);
   endtask

   // Start an op on the same edge that a byte is received.
   task automatic ci_op_with_byte(input logic [1:0] op, input logic [7:0] b,
                                  input string tag, input logic [31:0] exp);
      @(negedge clk);
      n        = op;
      start    = 1'b1;
      clk_en   = 1'b1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      check_eq({tag, " done"}, 32'(done), 32'd1);
      check_eq({tag, " result"}, result, exp);
   endtask

   initial begin
      reset = 1'b1; clk_en = 1'b0; start = 1'b0; n = 2'd0;
      rx_data = 8'h00; rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst done", 32'(done), 32'd0);
      check_eq("rst result", result, 32'h0);
      check_eq("rst overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      ci_op(OP_STATUS, "rst status", ST_BASE);

      send_byte(8'h1C);
      ci_op(OP_POP, "single pop", 32'h0000_001C);
      ci_op(OP_STATUS, "single status", ST_BASE);

      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
      ci_op(OP_PEEK, "peek1", 32'h00E0_F074);
      ci_op(OP_PEEK, "peek2", 32'h00E0_F074);
      ci_op(OP_POP, "pop3", 32'h00E0_F074);
      ci_op(OP_PEEK, "peek empty", 32'h0);
      ci_op(OP_POP, "pop empty", 32'h0);

      // a fourth prefix byte terminates a MAX_BYTES-long code
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'hF0);
      ci_op(OP_POP, "pop maxlen", 32'hE0F0_E0F0);

      send_byte(8'hE0);
      ci_op(OP_STATUS, "collect status", ST_BASE | 32'h4000_0000);
      repeat (TIMEOUT + 1) @(negedge clk);
      ci_op(OP_STATUS, "timeout status", ST_BASE);
      send_byte(8'h1C);
      ci_op(OP_POP, "post-timeout pop", 32'h0000_001C);

      for (int i = 1; i <= 9; i++) send_byte(8'(i));
      check_eq("ovf flag", 32'(overflow), 32'd1);
      ci_op(OP_STATUS, "ovf status", ST_BASE | 32'h8000_0008);
      for (int i = 1; i <= 8; i++) ci_op(OP_POP, "ovf pop", 32'(i));
      ci_op(OP_CLEAR, "clear", 32'h0);
      check_eq("clear ovf", 32'(overflow), 32'd0);
      ci_op(OP_STATUS, "clear status", ST_BASE);

      for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
      ci_op(OP_STATUS, "full status", ST_BASE | 32'd8);
      ci_op_with_byte(OP_POP, 8'h2A, "full pop+push", 32'h0000_0011);
      check_eq("full pop+push ovf", 32'(overflow), 32'd0);
      ci_op(OP_STATUS, "full after", ST_BASE | 32'd8);
      for (int i = 1; i < 8; i++) ci_op(OP_POP, "drain", 32'(8'h11 + i));
      ci_op(OP_POP, "drain last", 32'h0000_002A);

      ci_op_with_byte(OP_POP, 8'h33, "empty pop+push", 32'h0);
      ci_op(OP_PEEK, "empty pop+push peek", 32'h0000_0033);
      ci_op(OP_POP, "empty pop+push pop", 32'h0000_0033);

      send_byte(8'h66);
      ci_op_with_byte(OP_CLEAR, 8'h44, "clear+push", 32'h0);
      ci_op(OP_STATUS, "clear+push status", ST_BASE);

      // clk_en low stalls the response; a start while in RESP is ignored
      send_byte(8'h55);
      @(negedge clk);
      n = OP_POP; start = 1'b1; clk_en = 1'b1;
      @(negedge clk);
      start = 1'b0; clk_en = 1'b0;
      #1 check_eq("stall done0", 32'(done), 32'd0);
      @(negedge clk);
      check_eq("stall done1", 32'(done), 32'd0);
      clk_en = 1'b1; n = OP_STATUS; start = 1'b1;
      #1 check_eq("stall done", 32'(done), 32'd1);
      check_eq("stall result", result, 32'h0000_0055);
      @(negedge clk);
      start = 1'b0;
      check_eq("resp start ignored done", 32'(done), 32'd0);
      check_eq("resp start ignored result", result, 32'h0000_0055);
      ci_op(OP_STATUS, "stall status", ST_BASE);

      send_byte(8'hE0);
      @(negedge clk);
      n = OP_PEEK; start = 1'b1; clk_en = 1'b1;
      @(negedge clk);
      start = 1'b0; reset = 1'b1;
      #1 check_eq("midrst done", 32'(done), 32'd0);
      check_eq("midrst result", result, 32'h0);
      check_eq("midrst overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("postrst done", 32'(done), 32'd0);
      ci_op(OP_STATUS, "postrst status", ST_BASE);
      send_byte(8'h1C);
      ci_op(OP_POP, "postrst pop", 32'h0000_001C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
